// File: rtl/anabellek_hakemi.sv
// Arbitrates I-cache and D-cache block requests onto one main-memory port; round-robin on ties.
// Grant to memory request is 1 cycle; completion pulse 1 cycle after hazir or timeout; requesters hold istek until gecerli.
module anabellek_hakemi #(
  parameter int unsigned ZAMAN_ASIMI = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         buyruk_istek_i,
  input  logic [31:0]  buyruk_adres_i,
  output logic [127:0] buyruk_obek_o,
  output logic         buyruk_obek_gecerli_o,
  input  logic         veri_istek_i,
  input  logic         veri_yaz_i,
  input  logic [31:0]  veri_adres_i,
  input  logic [127:0] veri_obek_i,
  output logic [127:0] veri_obek_o,
  output logic         veri_obek_gecerli_o,
  output logic         bellek_istek_o,
  output logic         bellek_yaz_o,
  output logic [31:0]  bellek_adres_o,
  output logic [127:0] bellek_obek_o,
  input  logic [127:0] bellek_obek_i,
  input  logic         bellek_hazir_i,
  output logic         hata_o,
  output logic         mesgul_o
);

  typedef enum logic [2:0] {
    BOSTA,
    BUYRUK_OKU,
    VERI_OKU,
    VERI_YAZ,
    BITTI
  } durum_t;

  localparam logic [15:0] SINIR = ZAMAN_ASIMI[15:0];

  durum_t       durum_q, durum_d;
  logic         son_verilen_q, son_verilen_d;  // 1: data cache was granted last
  logic [15:0]  sayac_q, sayac_d;
  logic [31:0]  adres_d;
  logic [127:0] yaz_obek_d;
  logic [127:0] buyruk_obek_d, veri_obek_d;
  logic         buyruk_gec_d, veri_gec_d, hata_d;

  // Block addresses are aligned; the low nibble of the request address is dropped.
  logic unused_adres_bitleri;
  assign unused_adres_bitleri = ^{buyruk_adres_i[3:0], veri_adres_i[3:0]};

  always_comb begin
    durum_d       = durum_q;
    son_verilen_d = son_verilen_q;
    sayac_d       = sayac_q;
    adres_d       = bellek_adres_o;
    yaz_obek_d    = bellek_obek_o;
    buyruk_obek_d = buyruk_obek_o;
    veri_obek_d   = veri_obek_o;
    buyruk_gec_d  = 1'b0;
    veri_gec_d    = 1'b0;
    hata_d        = 1'b0;

    case (durum_q)
      BOSTA: begin
        if (buyruk_istek_i && (!veri_istek_i || son_verilen_q)) begin
          durum_d       = BUYRUK_OKU;
          son_verilen_d = 1'b0;
          sayac_d       = 16'd0;
          adres_d       = {buyruk_adres_i[31:4], 4'b0000};
        end else if (veri_istek_i) begin
          durum_d       = veri_yaz_i ? VERI_YAZ : VERI_OKU;
          son_verilen_d = 1'b1;
          sayac_d       = 16'd0;
          adres_d       = {veri_adres_i[31:4], 4'b0000};
          if (veri_yaz_i) begin
            yaz_obek_d = veri_obek_i;
          end
        end
      end

      BUYRUK_OKU, VERI_OKU, VERI_YAZ: begin
        if (bellek_hazir_i) begin
          durum_d = BITTI;
          if (durum_q == BUYRUK_OKU) begin
            buyruk_gec_d  = 1'b1;
            buyruk_obek_d = bellek_obek_i;
          end else begin
            veri_gec_d = 1'b1;
            if (durum_q == VERI_OKU) begin
              veri_obek_d = bellek_obek_i;
            end
          end
        end else begin
          sayac_d = sayac_q + 16'd1;
          // Timeout: complete with an error pulse and a zeroed read block.
          if (sayac_d == SINIR) begin
            durum_d = BITTI;
            hata_d  = 1'b1;
            if (durum_q == BUYRUK_OKU) begin
              buyruk_gec_d  = 1'b1;
              buyruk_obek_d = '0;
            end else begin
              veri_gec_d = 1'b1;
              if (durum_q == VERI_OKU) begin
                veri_obek_d = '0;
              end
            end
          end
        end
      end

      BITTI: durum_d = BOSTA;

      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q               <= BOSTA;
      son_verilen_q         <= 1'b1;
      sayac_q               <= 16'd0;
      buyruk_obek_o         <= '0;
      buyruk_obek_gecerli_o <= 1'b0;
      veri_obek_o           <= '0;
      veri_obek_gecerli_o   <= 1'b0;
      bellek_istek_o        <= 1'b0;
      bellek_yaz_o          <= 1'b0;
      bellek_adres_o        <= '0;
      bellek_obek_o         <= '0;
      hata_o                <= 1'b0;
      mesgul_o              <= 1'b0;
    end else begin
      durum_q               <= durum_d;
      son_verilen_q         <= son_verilen_d;
      sayac_q               <= sayac_d;
      buyruk_obek_o         <= buyruk_obek_d;
      buyruk_obek_gecerli_o <= buyruk_gec_d;
      veri_obek_o           <= veri_obek_d;
      veri_obek_gecerli_o   <= veri_gec_d;
      bellek_istek_o        <= (durum_d == BUYRUK_OKU) || (durum_d == VERI_OKU) ||
                               (durum_d == VERI_YAZ);
      bellek_yaz_o          <= (durum_d == VERI_YAZ);
      bellek_adres_o        <= adres_d;
      bellek_obek_o         <= yaz_obek_d;
      hata_o                <= hata_d;
      mesgul_o              <= (durum_d != BOSTA);
    end
  end

endmodule
